// File: rtl/ooo_types_pkg.sv
// ooo_types_pkg: shared reorder-buffer types (tags, cause codes, entry layout).
package ooo_types_pkg;
    localparam int ROB_DEPTH = 8;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
    localparam int LS_PORT   = 3;
    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    typedef enum logic [1:0] {FU_AU, FU_MU, FU_DU, FU_LS} scalar_fu_t;
    typedef enum logic [3:0] {
        MAL_INSN, FAULT_INSN, ILLEGAL, BREAK, ENV_M, MAL_L, FAULT_L, MAL_S, FAULT_S
    } rob_cause_t;
    typedef struct packed {
        logic        valid;
        logic        done;
        logic        exc;
        rob_cause_t  cause;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        scalar_fu_t  fu;
        logic [31:0] data;
        logic [31:0] badaddr;
    } rob_entry_t;
endpackage

// File: rtl/ooo_reorder_buffer.sv
// ooo_reorder_buffer: in-order retirement buffer with tagged writeback and precise exceptions.
module ooo_reorder_buffer
    import ooo_types_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 4,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    alloc_valid,
    input  logic [31:0]             alloc_pc,
    input  logic [4:0]              alloc_rd,
    input  logic                    alloc_wen,
    input  scalar_fu_t              alloc_fu,
    output logic [TAG_W-1:0]        alloc_tag,
    output logic                    rob_full,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [NUM_WB*32-1:0]    wb_data,
    input  logic [NUM_WB-1:0]       wb_exc,
    input  logic [NUM_WB*4-1:0]     wb_cause,
    input  logic [31:0]             wb_badaddr,
    output logic                    commit_valid,
    output logic [4:0]              commit_rd,
    output logic                    commit_wen,
    output logic [31:0]             commit_data,
    output logic                    commit_exc,
    output logic [3:0]              commit_cause,
    output logic [31:0]             epc,
    output logic [31:0]             badaddr,
    output logic                    ex_comm_flush
);
    rob_entry_t       ent [DEPTH];
    rob_entry_t       hd;
    logic [TAG_W:0]   head, tail;
    logic             do_alloc;
    assign hd            = ent[head[TAG_W-1:0]];
    assign rob_full      = (head[TAG_W] != tail[TAG_W]) && (head[TAG_W-1:0] == tail[TAG_W-1:0]);
    assign alloc_tag     = tail[TAG_W-1:0];
    assign commit_valid  = hd.valid && hd.done && !hd.exc;
    assign commit_exc    = hd.valid && hd.done && hd.exc;
    assign ex_comm_flush = commit_exc;
    assign commit_wen    = commit_valid && hd.wen;
    assign commit_rd     = commit_valid ? hd.rd : '0;
    assign commit_data   = commit_valid ? hd.data : '0;
    assign commit_cause  = commit_exc ? hd.cause : '0;
    assign do_alloc      = alloc_valid && !rob_full && !ex_comm_flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head    <= '0;
            tail    <= '0;
            epc     <= '0;
            badaddr <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (ex_comm_flush) begin
            epc     <= hd.pc;
            badaddr <= hd.badaddr;
            head    <= '0;
            tail    <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
        end else begin
            // descending order so the lowest-numbered port wins a duplicate tag
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_valid[p] && ent[wb_tag[p*TAG_W +: TAG_W]].valid) begin
                    ent[wb_tag[p*TAG_W +: TAG_W]].done    <= 1'b1;
                    ent[wb_tag[p*TAG_W +: TAG_W]].data    <= wb_data[p*32 +: 32];
                    ent[wb_tag[p*TAG_W +: TAG_W]].exc     <= wb_exc[p];
                    ent[wb_tag[p*TAG_W +: TAG_W]].cause   <= rob_cause_t'(wb_cause[p*4 +: 4]);
                    ent[wb_tag[p*TAG_W +: TAG_W]].badaddr <= (p == LS_PORT) ? wb_badaddr : '0;
                end
            end
            if (do_alloc) begin
                ent[tail[TAG_W-1:0]] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0, cause: MAL_INSN,
                                          pc: alloc_pc, rd: alloc_rd, wen: alloc_wen, fu: alloc_fu,
                                          data: '0, badaddr: '0};
                tail <= tail + (TAG_W+1)'(1);
            end
            if (commit_valid) begin
                ent[head[TAG_W-1:0]].valid <= 1'b0;
                head <= head + (TAG_W+1)'(1);
            end
        end
    end

    for (genvar a = 0; a < NUM_WB; a++) begin : g_a
        for (genvar b = a + 1; b < NUM_WB; b++) begin : g_b
            assert property (@(posedge CLK) disable iff (!nRST)
                !(wb_valid[a] && wb_valid[b] && wb_tag[a*TAG_W +: TAG_W] == wb_tag[b*TAG_W +: TAG_W]));
        end
    end
endmodule

// File: tb/tb_ooo_reorder_buffer.sv
// tb_ooo_reorder_buffer: vector table plus commit scoreboard for the reorder buffer.
module tb_ooo_reorder_buffer;
    import ooo_types_pkg::*;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic [4:0]  alloc_rd;
    logic        alloc_wen;
    scalar_fu_t  alloc_fu;
    logic [2:0]  alloc_tag;
    logic        rob_full;
    logic [3:0]  wb_valid;
    logic [11:0] wb_tag;
    logic [127:0] wb_data;
    logic [3:0]  wb_exc;
    logic [15:0] wb_cause;
    logic [31:0] wb_badaddr;
    logic        commit_valid, commit_wen, commit_exc, ex_comm_flush;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data, epc, badaddr;
    logic [3:0]  commit_cause;

    ooo_reorder_buffer dut (
        .CLK(CLK), .nRST(nRST),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_rd(alloc_rd),
        .alloc_wen(alloc_wen), .alloc_fu(alloc_fu), .alloc_tag(alloc_tag), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc),
        .wb_cause(wb_cause), .wb_badaddr(wb_badaddr),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_wen(commit_wen),
        .commit_data(commit_data), .commit_exc(commit_exc), .commit_cause(commit_cause),
        .epc(epc), .badaddr(badaddr), .ex_comm_flush(ex_comm_flush)
    );

    always #5 CLK = ~CLK;

    typedef struct {logic [4:0] rd; logic wen; logic [31:0] data;} exp_t;
    typedef struct {logic av; logic [2:0] tag; logic full;} vec_t;
    exp_t        sb[$];
    vec_t        vt[10];
    logic [31:0] tag_data[8];
    logic [2:0]  mtail;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_wb(input int p, input logic [2:0] t, input logic exc, input logic [3:0] c,
                          input logic [31:0] ba);
        wb_valid[p]        = 1'b1;
        wb_tag[p*3 +: 3]   = t;
        wb_data[p*32 +: 32] = tag_data[t];
        wb_exc[p]          = exc;
        wb_cause[p*4 +: 4] = c;
        if (p == 3) wb_badaddr = ba;
    endtask

    task automatic clr_wb();
        wb_valid = '0; wb_tag = '0; wb_data = '0; wb_exc = '0; wb_cause = '0; wb_badaddr = '0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic wen, input logic [31:0] pc,
                         input logic [31:0] d, input logic exp_commit);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_rd = rd; alloc_wen = wen; alloc_fu = FU_LS;
        #1;
        chk("alloc_tag", {29'd0, alloc_tag}, {29'd0, mtail});
        chk("alloc_not_full", {31'd0, rob_full}, 32'd0);
        tag_data[mtail] = d;
        if (exp_commit) sb.push_back('{rd, wen, d});
        tick();
        alloc_valid = 1'b0;
        mtail++;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        chk(name, sb.size(), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (nRST && commit_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_commit: got rd %0d data %h expected no commit", commit_rd, commit_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("commit_rd", {27'd0, commit_rd}, {27'd0, e.rd});
                chk("commit_wen", {31'd0, commit_wen}, {31'd0, e.wen});
                chk("commit_data", commit_data, e.data);
            end
        end
    end

    initial begin
        nRST = 1'b0; alloc_valid = 1'b0; alloc_pc = '0; alloc_rd = '0; alloc_wen = 1'b0;
        alloc_fu = FU_AU; mtail = '0;
        clr_wb();
        for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 3'(i), 1'b0};
        vt[8] = '{1'b1, 3'd0, 1'b1};
        vt[9] = '{1'b0, 3'd0, 1'b1};
        #12;
        chk("rst_full", {31'd0, rob_full}, 32'd0);
        chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
        chk("rst_commit_exc", {31'd0, commit_exc}, 32'd0);
        chk("rst_flush", {31'd0, ex_comm_flush}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_badaddr", badaddr, 32'd0);
        chk("rst_tag", {29'd0, alloc_tag}, 32'd0);
        tick();
        nRST = 1'b1;

        // fill with no writeback: tags 0..7 then full, extra alloc not consumed
        for (int i = 0; i < 10; i++) begin
            alloc_valid = vt[i].av; alloc_pc = 32'h1000 + 32'(i * 4); alloc_rd = 5'(i);
            alloc_wen = 1'b1;
            #1;
            chk($sformatf("fill_tag%0d", i), {29'd0, alloc_tag}, {29'd0, vt[i].tag});
            chk($sformatf("fill_full%0d", i), {31'd0, rob_full}, {31'd0, vt[i].full});
            chk($sformatf("fill_nocommit%0d", i), {31'd0, commit_valid}, 32'd0);
            tick();
        end
        alloc_valid = 1'b0;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        mtail = '0;

        // out-of-order writeback, in-order retirement
        alloc(5'd1, 1'b1, 32'h200, 32'h1111_0000, 1'b1);
        alloc(5'd2, 1'b0, 32'h204, 32'h2222_0000, 1'b1);
        alloc(5'd3, 1'b1, 32'h208, 32'h3333_0000, 1'b1);
        set_wb(3, 3'd2, 1'b0, 4'd0, 32'h0);
        #1 chk("ooo_wb2_nocommit", {31'd0, commit_valid}, 32'd0);
        tick(); clr_wb(); set_wb(1, 3'd1, 1'b0, 4'd0, 32'h0);
        #1 chk("ooo_wb1_nocommit", {31'd0, commit_valid}, 32'd0);
        tick(); clr_wb(); set_wb(0, 3'd0, 1'b0, 4'd0, 32'h0);
        #1 chk("ooo_wb0_nocommit", {31'd0, commit_valid}, 32'd0);
        tick(); clr_wb();
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("ooo_commit%0d", k), {31'd0, commit_valid}, 32'd1);
            tick();
        end
        #1 chk("ooo_done", {31'd0, commit_valid}, 32'd0);
        chk("ooo_sb_empty", sb.size(), 32'd0);

        // precise exception on the head
        begin
            logic [2:0] t0;
            t0 = mtail;
            alloc(5'd4, 1'b1, 32'h100, 32'h5555_0000, 1'b0);
            alloc(5'd5, 1'b1, 32'h104, 32'h6666_0000, 1'b0);
            set_wb(3, t0, 1'b1, FAULT_L, 32'hDEAD_0000);
            #1 chk("exc_wb_noexc", {31'd0, commit_exc}, 32'd0);
            tick(); clr_wb();
            #1;
            chk("exc_commit_exc", {31'd0, commit_exc}, 32'd1);
            chk("exc_flush", {31'd0, ex_comm_flush}, 32'd1);
            chk("exc_no_valid", {31'd0, commit_valid}, 32'd0);
            chk("exc_cause", {28'd0, commit_cause}, {28'd0, FAULT_L});
            tick();
            mtail = '0;
            #1;
            chk("exc_epc", epc, 32'h100);
            chk("exc_badaddr", badaddr, 32'hDEAD_0000);
            chk("exc_pulse", {31'd0, commit_exc}, 32'd0);
            chk("exc_empty_tag", {29'd0, alloc_tag}, 32'd0);
            chk("exc_empty_full", {31'd0, rob_full}, 32'd0);
            set_wb(0, t0 + 3'd1, 1'b0, 4'd0, 32'h0);
            tick(); clr_wb();
            #1 chk("exc_tag1_gone", {31'd0, commit_valid}, 32'd0);
            tick();
        end

        // full buffer: commit and blocked alloc in the same cycle
        for (int i = 0; i < 8; i++)
            alloc(5'(8 + i), 1'b1, 32'h300 + 32'(i * 4), 32'h4000 + 32'(i), 1'b1);
        #1 chk("full_after8", {31'd0, rob_full}, 32'd1);
        set_wb(0, 3'd0, 1'b0, 4'd0, 32'h0);
        tick(); clr_wb();
        alloc_valid = 1'b1; alloc_pc = 32'h400; alloc_rd = 5'd20; alloc_wen = 1'b1;
        #1;
        chk("full_commit", {31'd0, commit_valid}, 32'd1);
        chk("full_block", {31'd0, rob_full}, 32'd1);
        chk("full_block_tag", {29'd0, alloc_tag}, 32'd0);
        tick();
        chk("full_release", {31'd0, rob_full}, 32'd0);
        chk("full_wrap_tag", {29'd0, alloc_tag}, 32'd0);
        tag_data[0] = 32'h4444;
        sb.push_back('{5'd20, 1'b1, 32'h4444});
        tick();
        alloc_valid = 1'b0;
        mtail = 3'd1;
        chk("full_next_tag", {29'd0, alloc_tag}, 32'd1);
        for (int p = 0; p < 4; p++) set_wb(p, 3'(p + 1), 1'b0, 4'd0, 32'h0);
        tick(); clr_wb();
        set_wb(0, 3'd5, 1'b0, 4'd0, 32'h0);
        set_wb(1, 3'd6, 1'b0, 4'd0, 32'h0);
        set_wb(2, 3'd7, 1'b0, 4'd0, 32'h0);
        set_wb(3, 3'd0, 1'b0, 4'd0, 32'h0);
        tick(); clr_wb();
        drain("full_drain");

        // writeback to an invalid tag while empty
        tag_data[5] = 32'hBAD0_0005;
        set_wb(0, 3'd5, 1'b0, 4'd0, 32'h0);
        #1 chk("inv_nocommit0", {31'd0, commit_valid}, 32'd0);
        tick(); clr_wb();
        #1;
        chk("inv_nocommit1", {31'd0, commit_valid}, 32'd0);
        chk("inv_noexc", {31'd0, commit_exc}, 32'd0);
        chk("inv_full", {31'd0, rob_full}, 32'd0);
        chk("inv_tag", {29'd0, alloc_tag}, {29'd0, mtail});
        tick();

        // asynchronous reset with entries in flight
        for (int i = 0; i < 4; i++)
            alloc(5'(24 + i), 1'b1, 32'h500 + 32'(i * 4), 32'h7000 + 32'(i), 1'b0);
        set_wb(1, mtail - 3'd3, 1'b0, 4'd0, 32'h0);
        set_wb(2, mtail - 3'd2, 1'b0, 4'd0, 32'h0);
        tick(); clr_wb();
        #1 chk("inflight_nocommit", {31'd0, commit_valid}, 32'd0);
        nRST = 1'b0;
        #1;
        chk("arst_tag", {29'd0, alloc_tag}, 32'd0);
        chk("arst_full", {31'd0, rob_full}, 32'd0);
        chk("arst_epc", epc, 32'd0);
        chk("arst_badaddr", badaddr, 32'd0);
        chk("arst_commit", {31'd0, commit_valid | commit_exc | ex_comm_flush}, 32'd0);
        tick();
        nRST = 1'b1;
        sb.delete();
        mtail = '0;
        alloc(5'd30, 1'b1, 32'h600, 32'hC0DE_0000, 1'b1);
        set_wb(2, 3'd0, 1'b0, 4'd0, 32'h0);
        tick(); clr_wb();
        drain("post_rst_drain");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
